wom_drain: RTL and testbench
============================

Name: wom_drain

Overview:
- Reader end of the write-only result memory (WOM): the memory stage writes four 32-bit lane results per address; this block reads them back out.
- On a start command it walks n consecutive WOM addresses from a base address.
- For each address it reads all four lanes and serializes them as a byte stream over a valid/ready handshake toward the host link.
- Sits beside the Memory block and shares the WOM read port with nothing else.

Parameters:
- ADDR_W, 32, width of WOM address and entry count.
- ADDR_STEP, 1, address increment between consecutive vector entries.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle command pulse; sampled only in IDLE.
- abort  in  1  synchronous cancel of a drain in progress.
- base_addr  in  ADDR_W  first WOM address; latched on an accepted start.
- n  in  ADDR_W  number of entries to drain; latched on an accepted start.
- wom_rd_en  out  1  WOM read strobe.
- wom_rd_addr  out  ADDR_W  WOM read address.
- wom_rd_data1..wom_rd_data4  in  32 each  lane 1..4 read data, valid exactly 1 cycle after wom_rd_en.
- tx_data  out  8  output byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  downstream accepts the byte.
- busy  out  1  high in every state other than IDLE.
- done  out  1  one-cycle pulse when a drain completes normally.

Behaviour:
- Reset (async, rst=1): state=IDLE; wom_rd_en=0, wom_rd_addr=0, tx_data=0, tx_valid=0, busy=0, done=0; internal address, remaining count, byte index and the 128-bit shift register cleared.
- States: IDLE, READ, WAIT, SEND, FIN.
- IDLE:
  - start=1 with n!=0: latch base_addr and n, go to READ.
  - start=1 with n==0: go to FIN; no WOM read occurs.
  - start is ignored in every state other than IDLE.
- READ (1 cycle): wom_rd_en=1, wom_rd_addr=current address; go to WAIT.
- WAIT (1 cycle): capture {data4,data3,data2,data1} into the shift register; byte index=0; go to SEND.
- SEND:
  - tx_valid=1.
  - Byte order: lane1 first, lane4 last; within each lane little-endian (bits 7:0 first). 16 bytes per entry.
  - The byte advances only on tx_valid&&tx_ready.
  - tx_data and tx_valid hold stable while tx_ready=0.
  - On acceptance of byte 15: address += ADDR_STEP (wraps modulo 2^ADDR_W) and remaining -= 1.
  - If remaining is now 0, go to FIN; otherwise go to READ. tx_valid drops for the READ/WAIT gap of 2 cycles.
- FIN (1 cycle): done=1, busy=1; go to IDLE.
- Minimum latency: start to first tx_valid = 3 cycles (start edge → READ → WAIT → SEND).
- abort=1 in any non-IDLE state: next state IDLE, tx_valid=0 next cycle, no done pulse. A byte handshaked in the same cycle counts as transferred. abort has priority over all other transitions, including the FIN→IDLE transition (done still pulses in that FIN cycle).
- wom_rd_en is never asserted outside READ.
- Address and n are held internally, so changing base_addr or n during a drain has no effect.
- Reset mid-drain: immediate return to the reset state; no done pulse.

Test Plan:
- Single entry: WOM[0] lanes = 55, 8, 10, 11; start with base=0, n=1, tx_ready=1 → wom_rd_en exactly once at addr 0; bytes 0x37,0,0,0,0x08,0,0,0,0x0A,0,0,0,0x0B,0,0,0; first tx_valid 3 cycles after start; done 1 cycle after the last byte; busy low afterward.
- Multi-entry with stride: ADDR_STEP=1, base=4, n=3, WOM[4..6] lane1 = 0x11223344, 0xA, 0xB → reads at addrs 4, 5, 6; 48 bytes total, beginning 0x44,0x33,0x22,0x11; exactly 2 non-valid cycles between entries.
- Backpressure: tx_ready toggling 1,0,0,1,... → no byte is lost or duplicated; tx_data stays constant while tx_ready=0; stream identical to the tx_ready=1 case.
- n=0: start with n=0 → no wom_rd_en; done pulses 1 cycle later; no tx_valid.
- Abort and ignored start: abort asserted after byte 5 of an n=2 drain → tx_valid=0 next cycle, IDLE, no done. A start issued during a drain → ignored; the original drain completes unchanged.
- Reset: async rst pulsed mid-SEND (between clock edges) → all outputs 0 immediately; a new start with n=1 afterwards drains correctly.

Source files
------------

// File: rtl/wom_drain.sv
// Drains n consecutive four-lane WOM entries and serializes each one as 16 bytes
// (lane 1 first, each lane little-endian) over a valid/ready byte stream.
module wom_drain #(
  parameter int ADDR_W    = 32,
  parameter int ADDR_STEP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] n,
  output logic              wom_rd_en,
  output logic [ADDR_W-1:0] wom_rd_addr,
  input  logic [31:0]       wom_rd_data1,
  input  logic [31:0]       wom_rd_data2,
  input  logic [31:0]       wom_rd_data3,
  input  logic [31:0]       wom_rd_data4,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, READ, WAIT, SEND, FIN} state_t;

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   rem_q, rem_d;
  logic [3:0]          idx_q, idx_d;
  logic [127:0]        sr_q, sr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      sr_q    <= sr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    idx_d       = idx_q;
    sr_d        = sr_q;
    wom_rd_en   = 1'b0;
    wom_rd_addr = addr_q;
    tx_data     = 8'h00;
    tx_valid    = 1'b0;
    busy        = (state_q != IDLE);
    done        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = base_addr;
          rem_d   = n;
          state_d = (n == '0) ? FIN : READ;
        end
      end
      READ: begin
        wom_rd_en = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        sr_d    = {wom_rd_data4, wom_rd_data3, wom_rd_data2, wom_rd_data1};
        idx_d   = 4'd0;
        state_d = SEND;
      end
      SEND: begin
        tx_valid = 1'b1;
        tx_data  = sr_q[7:0];
        // The lowest byte of the shift register is always the one on the wire.
        if (tx_ready) begin
          sr_d  = {8'h00, sr_q[127:8]};
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'd15) begin
            addr_d  = addr_q + STEP;
            rem_d   = rem_q - ONE;
            state_d = (rem_q == ONE) ? FIN : READ;
          end
        end
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Cancel wins over every other transition; a same-cycle handshake still counts.
    if (abort && (state_q != IDLE)) state_d = IDLE;
  end

endmodule

// File: tb/tb_wom_drain.sv
// Directed bench for wom_drain: WOM read model, byte monitor and a linear sequence
// of scenarios checked with immediate assertions.
module tb_wom_drain;

  logic        clk = 1'b0;
  logic        rst, start, abort, tx_ready;
  logic [31:0] base_addr, n;
  logic        wom_rd_en;
  logic [31:0] wom_rd_addr;
  logic [31:0] rd1, rd2, rd3, rd4;
  logic [7:0]  tx_data;
  logic        tx_valid, busy, done;

  always #5 clk = ~clk;

  wom_drain #(.ADDR_W(32), .ADDR_STEP(1)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .base_addr(base_addr), .n(n),
    .wom_rd_en(wom_rd_en), .wom_rd_addr(wom_rd_addr),
    .wom_rd_data1(rd1), .wom_rd_data2(rd2), .wom_rd_data3(rd3), .wom_rd_data4(rd4),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done)
  );

  logic [31:0] wom [16][4];

  always @(posedge clk) begin
    if (wom_rd_en) begin
      rd1 <= wom[wom_rd_addr[3:0]][0];
      rd2 <= wom[wom_rd_addr[3:0]][1];
      rd3 <= wom[wom_rd_addr[3:0]][2];
      rd4 <= wom[wom_rd_addr[3:0]][3];
    end
  end

  // Monitor: values seen at a rising edge belong to the cycle ending there.
  int          cyc = 0;
  logic [7:0]  got_q[$];
  int          stamp_q[$];
  logic [31:0] rdaddr_q[$];
  int          done_cnt, done_stamp, valid_cnt;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (wom_rd_en) rdaddr_q.push_back(wom_rd_addr);
    if (tx_valid) valid_cnt = valid_cnt + 1;
    if (tx_valid && tx_ready) begin
      got_q.push_back(tx_data);
      stamp_q.push_back(cyc);
    end
    if (done) begin
      done_cnt   = done_cnt + 1;
      done_stamp = cyc;
    end
  end

  int passed = 0;
  int total  = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic clr();
    got_q.delete(); stamp_q.delete(); rdaddr_q.delete();
    done_cnt = 0; done_stamp = 0; valid_cnt = 0;
  endtask

  // Reference stream: lane 1..4 of each entry, each lane low byte first.
  task automatic build_exp(input int b, input int cnt);
    exp_q.delete();
    for (int e = 0; e < cnt; e++)
      for (int l = 0; l < 4; l++)
        for (int k = 0; k < 4; k++)
          exp_q.push_back(wom[(b + e) % 16][l][8*k +: 8]);
  endtask

  function automatic int stream_err();
    int errs = (got_q.size() == exp_q.size()) ? 0 : 1000;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) errs++;
    return errs;
  endfunction

  task automatic pulse_start(input logic [31:0] b, input logic [31:0] c);
    base_addr = b; n = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 0;
    for (int i = 0; i < 500; i++) begin
      if (!busy) begin ok = 1; break; end
      @(negedge clk);
    end
    chk(tag, 64'(ok), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] t1_exp [16];
  bit         prev_hold;
  logic [7:0] prev_data;
  int         hold_err, bp_ok;
  bit         bp_pat [4];

  initial begin
    t1_exp = '{8'h37, 8'h00, 8'h00, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00,
               8'h0A, 8'h00, 8'h00, 8'h00, 8'h0B, 8'h00, 8'h00, 8'h00};
    bp_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int a = 0; a < 16; a++)
      for (int l = 0; l < 4; l++)
        wom[a][l] = 32'hC0DE0000 | (a << 8) | (l << 4) | (a ^ l);
    wom[0] = '{32'd55, 32'd8, 32'd10, 32'd11};
    wom[4][0] = 32'h11223344;
    wom[5][0] = 32'h0000000A;
    wom[6][0] = 32'h0000000B;
    rd1 = '0; rd2 = '0; rd3 = '0; rd4 = '0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; base_addr = '0; n = '0; tx_ready = 1'b1;
    clr();
    repeat (2) @(negedge clk);
    chk("rst_outputs", {wom_rd_en, tx_valid, busy, done, tx_data, wom_rd_addr},
        64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single entry, full-rate sink
    clr();
    pulse_start(32'd0, 32'd1);
    chk("t1_rden", 64'(wom_rd_en), 64'd1);
    chk("t1_rdaddr", 64'(wom_rd_addr), 64'd0);
    chk("t1_valid_read", 64'(tx_valid), 64'd0);
    @(negedge clk);
    chk("t1_valid_wait", 64'(tx_valid), 64'd0);
    @(negedge clk);
    chk("t1_first_valid", {tx_valid, tx_data}, {1'b1, 8'h37});
    wait_idle("t1_timeout");
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(t1_exp[i]);
    chk("t1_stream", 64'(stream_err()), 64'd0);
    chk("t1_rd_count", 64'(rdaddr_q.size()), 64'd1);
    chk("t1_done_count", 64'(done_cnt), 64'd1);
    chk("t1_done_latency", 64'(done_stamp - stamp_q[15]), 64'd1);
    chk("t1_busy_after", 64'(busy), 64'd0);

    // Three entries from base 4
    clr();
    pulse_start(32'd4, 32'd3);
    wait_idle("t2_timeout");
    chk("t2_rd_addrs", {rdaddr_q.size() == 3 ? {rdaddr_q[0][7:0], rdaddr_q[1][7:0],
        rdaddr_q[2][7:0]} : 24'hFFFFFF}, 64'h040506);
    chk("t2_first4", {got_q.size() >= 4 ? {got_q[0], got_q[1], got_q[2], got_q[3]} : 32'h0},
        64'h44332211);
    build_exp(4, 3);
    chk("t2_stream", 64'(stream_err()), 64'd0);
    chk("t2_gaps", {stamp_q.size() == 48 ? {16'(stamp_q[16] - stamp_q[15]),
        16'(stamp_q[32] - stamp_q[31])} : 32'h0}, 64'h00030003);
    chk("t2_done_count", 64'(done_cnt), 64'd1);

    // Backpressure 1,0,0,1,...
    clr();
    hold_err = 0; prev_hold = 0; prev_data = 8'h00; bp_ok = 0;
    pulse_start(32'd4, 32'd3);
    for (int k = 0; k < 2000; k++) begin
      if (prev_hold && (!tx_valid || tx_data !== prev_data)) hold_err++;
      tx_ready  = bp_pat[k % 4];
      prev_hold = tx_valid && !tx_ready;
      prev_data = tx_data;
      @(negedge clk);
      if (!busy) begin bp_ok = 1; break; end
    end
    tx_ready = 1'b1;
    chk("t3_timeout", 64'(bp_ok), 64'd1);
    chk("t3_hold", 64'(hold_err), 64'd0);
    chk("t3_stream", 64'(stream_err()), 64'd0);
    chk("t3_done_count", 64'(done_cnt), 64'd1);

    // Empty drain
    clr();
    pulse_start(32'd2, 32'd0);
    chk("t4_done", {done, busy, wom_rd_en}, 64'b110);
    @(negedge clk);
    chk("t4_after", {done, busy}, 64'b00);
    repeat (2) @(negedge clk);
    chk("t4_no_activity", {24'(rdaddr_q.size()), 24'(valid_cnt), 16'(done_cnt)},
        {24'd0, 24'd0, 16'd1});

    // Abort after byte 5; the byte handshaked alongside abort still counts
    clr();
    pulse_start(32'd4, 32'd2);
    for (int i = 0; i < 100 && got_q.size() < 6; i++) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t5_abort_idle", {tx_valid, busy}, 64'b00);
    chk("t5_abort_bytes", 64'(got_q.size()), 64'd7);
    repeat (3) @(negedge clk);
    chk("t5_abort_no_done", {16'(done_cnt), 16'(rdaddr_q.size())}, {16'd0, 16'd1});

    // Start issued mid-drain is ignored
    clr();
    pulse_start(32'd5, 32'd1);
    repeat (2) @(negedge clk);
    pulse_start(32'd0, 32'd3);
    wait_idle("t5_ign_timeout");
    build_exp(5, 1);
    chk("t5_ign_stream", 64'(stream_err()), 64'd0);
    chk("t5_ign_rd", {16'(rdaddr_q.size()), rdaddr_q.size() > 0 ? rdaddr_q[0][15:0] : 16'hFFFF},
        {16'd1, 16'd5});
    chk("t5_ign_done", 64'(done_cnt), 64'd1);

    // Asynchronous reset mid-SEND, between clock edges
    clr();
    pulse_start(32'd0, 32'd1);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_rst", {wom_rd_en, tx_valid, busy, done, tx_data, wom_rd_addr}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_no_done", 64'(done_cnt), 64'd0);
    clr();
    pulse_start(32'd4, 32'd1);
    wait_idle("t6_timeout");
    build_exp(4, 1);
    chk("t6_stream", 64'(stream_err()), 64'd0);
    chk("t6_done", 64'(done_cnt), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
